// File: rtl/collision_player_multi.sv
// collision_player_multi
// Per-pixel player-vs-object collision detector for N_OBJ object channels.
// Each channel latches at most one hit per frame. A hit starts a cooldown
// that masks the channel for COOLDOWN_FRAMES whole frames. The block also
// reports the first channel hit in the frame, gives a summary of the previous
// frame's hits, and keeps a saturating total of hits.
module collision_player_multi #(
  parameter int N_OBJ           = 8,
  parameter int CNT_W           = 8,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       playerDrawingRequest,
  input  logic [N_OBJ-1:0]           objDrawingRequest,
  input  logic [N_OBJ-1:0]           chanEnable,
  input  logic                       clrCount,
  output logic [N_OBJ-1:0]           hitPulse,
  output logic                       anyHit,
  output logic [$clog2(N_OBJ)-1:0]   firstHitIdx,
  output logic [N_OBJ-1:0]           frameHitVec,
  output logic                       frameValid,
  output logic [CNT_W-1:0]           totalHitCount
);

  localparam int IDX_W = $clog2(N_OBJ);
  localparam int SUM_W = CNT_W + IDX_W + 1;
  localparam int CD_W  = 4;
  localparam logic [CD_W-1:0]  COOL_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [SUM_W-1:0] CNT_MAX   = SUM_W'({CNT_W{1'b1}});

  logic [CD_W-1:0]  coolCnt  [N_OBJ];
  logic [CD_W-1:0]  coolNext [N_OBJ];
  logic [N_OBJ-1:0] col;
  logic [N_OBJ-1:0] flagEff;
  logic [N_OBJ-1:0] newHits;
  logic [N_OBJ-1:0] hitNext;
  logic [IDX_W-1:0] newIdx;
  logic [SUM_W-1:0] hitSum;
  logic [SUM_W-1:0] sumAll;
  logic [CNT_W-1:0] countNext;

  // Cooldown seen by the current pixel. On startOfFrame the counters step
  // first, so a collision on that cycle uses the new frame's mask.
  always_comb begin
    for (int i = 0; i < N_OBJ; i++) begin
      coolNext[i] = coolCnt[i];
      if (startOfFrame) begin
        if (hitPulse[i])
          coolNext[i] = COOL_LOAD;
        else if (coolCnt[i] != '0)
          coolNext[i] = coolCnt[i] - 1'b1;
      end
    end
  end

  // Qualify collisions, find new hits, lowest new index and their popcount.
  always_comb begin
    flagEff = startOfFrame ? '0 : hitPulse;
    col     = '0;
    for (int i = 0; i < N_OBJ; i++)
      col[i] = playerDrawingRequest & objDrawingRequest[i] & chanEnable[i]
               & (coolNext[i] == '0);
    newHits = col & ~flagEff;
    hitNext = flagEff | newHits;
    newIdx  = '0;
    for (int i = N_OBJ - 1; i >= 0; i--)
      if (newHits[i]) newIdx = IDX_W'(i);
    hitSum = '0;
    for (int i = 0; i < N_OBJ; i++)
      hitSum = hitSum + SUM_W'(newHits[i]);
    sumAll    = SUM_W'(totalHitCount) + hitSum;
    countNext = (sumAll > CNT_MAX) ? {CNT_W{1'b1}} : sumAll[CNT_W-1:0];
  end

  // Register hit flags, summaries, counter and cooldowns.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hitPulse      <= '0;
      anyHit        <= 1'b0;
      firstHitIdx   <= '0;
      frameHitVec   <= '0;
      frameValid    <= 1'b0;
      totalHitCount <= '0;
      for (int i = 0; i < N_OBJ; i++) coolCnt[i] <= '0;
    end else begin
      hitPulse   <= hitNext;
      anyHit     <= |hitNext;
      frameValid <= startOfFrame;
      if (startOfFrame) frameHitVec <= hitPulse;
      if ((startOfFrame || !anyHit) && (newHits != '0)) firstHitIdx <= newIdx;
      if (clrCount) totalHitCount <= '0;
      else          totalHitCount <= countNext;
      for (int i = 0; i < N_OBJ; i++) coolCnt[i] <= coolNext[i];
    end
  end

endmodule

// File: tb/tb_collision_player_multi.sv
// Bench for collision_player_multi: two instances (C=0/CNT_W=8 and
// C=2/CNT_W=3) are driven by the same stimulus. A frame-numbered
// reference model predicts every output each cycle.
module tb_collision_player_multi;
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0, pdr = 1'b0, clr = 1'b0;
  logic [7:0] obj = '0, en = 8'hFF;

  logic [7:0] hp0, hp2, fv0, fv2;
  logic       ah0, ah2, val0, val2;
  logic [2:0] fi0, fi2;
  logic [7:0] cnt0;
  logic [2:0] cnt2;

  int total = 0;
  int bad = 0;

  collision_player_multi #(.N_OBJ(8), .CNT_W(8), .COOLDOWN_FRAMES(0)) dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .playerDrawingRequest(pdr),
    .objDrawingRequest(obj), .chanEnable(en), .clrCount(clr),
    .hitPulse(hp0), .anyHit(ah0), .firstHitIdx(fi0), .frameHitVec(fv0),
    .frameValid(val0), .totalHitCount(cnt0));

  collision_player_multi #(.N_OBJ(8), .CNT_W(3), .COOLDOWN_FRAMES(2)) dut2 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .playerDrawingRequest(pdr),
    .objDrawingRequest(obj), .chanEnable(en), .clrCount(clr),
    .hitPulse(hp2), .anyHit(ah2), .firstHitIdx(fi2), .frameHitVec(fv2),
    .frameValid(val2), .totalHitCount(cnt2));

  always #5 clk = ~clk;

  // Reference model, one slot per instance.
  int         coolOf [2] = '{0, 2};
  int         maxOf  [2] = '{255, 7};
  int         mFrame [2];
  int         mLast  [2][8];
  bit         mNever [2][8];
  logic [7:0] mHit   [2];
  logic [7:0] mPrev  [2];
  bit         mValid [2];
  int         mFirst [2];
  int         mCnt   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mFrame[k] = 0; mHit[k] = '0; mPrev[k] = '0; mValid[k] = 0;
      mFirst[k] = 0; mCnt[k] = 0;
      for (int i = 0; i < 8; i++) begin mNever[k][i] = 1; mLast[k][i] = 0; end
    end
  endtask

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] newv;
      int         pc;
      if (sof) begin
        mFrame[k]++; mPrev[k] = mHit[k]; mHit[k] = '0; mValid[k] = 1;
      end else mValid[k] = 0;
      newv = '0;
      for (int i = 0; i < 8; i++)
        if (pdr && obj[i] && en[i] && !mHit[k][i] &&
            (mNever[k][i] || mFrame[k] > mLast[k][i] + coolOf[k]))
          newv[i] = 1'b1;
      if (newv != 0) begin
        if (mHit[k] == 0)
          for (int i = 7; i >= 0; i--) if (newv[i]) mFirst[k] = i;
        mHit[k] = mHit[k] | newv;
        for (int i = 0; i < 8; i++)
          if (newv[i]) begin mLast[k][i] = mFrame[k]; mNever[k][i] = 0; end
      end
      pc = $countones(newv);
      if (clr) mCnt[k] = 0;
      else mCnt[k] = (mCnt[k] + pc > maxOf[k]) ? maxOf[k] : mCnt[k] + pc;
    end
  endtask

  task automatic checkAll();
    chk("hitPulse0", hp0, mHit[0]);
    chk("anyHit0", ah0, (mHit[0] != 0));
    chk("firstIdx0", fi0, mFirst[0]);
    chk("frameVec0", fv0, mPrev[0]);
    chk("frameValid0", val0, mValid[0]);
    chk("count0", cnt0, mCnt[0]);
    chk("hitPulse2", hp2, mHit[1]);
    chk("anyHit2", ah2, (mHit[1] != 0));
    chk("firstIdx2", fi2, mFirst[1]);
    chk("frameVec2", fv2, mPrev[1]);
    chk("frameValid2", val2, mValid[1]);
    chk("count2", cnt2, mCnt[1]);
  endtask

  task automatic step(input logic s, input logic p, input logic [7:0] o, input logic c);
    @(negedge clk);
    sof = s; pdr = p; obj = o; clr = c;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(0, 0, 8'h00, 0);
  endtask

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkAll();
    @(negedge clk) resetN = 1'b1;

    // Frame 1: obj3 overlaps at cycles 100..110.
    step(1, 0, 8'h00, 0);
    idle(99);
    for (int j = 0; j < 11; j++) begin
      step(0, 1, 8'h08, 0);
      if (j == 0) chk("tp1_hit_next_cycle", hp0, 8'h08);
    end
    idle(5);
    chk("tp1_count", cnt0, 1);
    chk("tp1_first", fi0, 3);
    step(1, 0, 8'h00, 0);
    chk("tp1_frameVec", fv0, 8'h08);
    chk("tp1_frameValid", val0, 1);
    chk("tp1_hit_cleared", hp0, 8'h00);
    step(0, 0, 8'h00, 0);
    chk("tp1_valid_one_cycle", val0, 0);

    // Simultaneous obj5+obj2, then obj0.
    idle(5);
    step(0, 1, 8'h24, 0);
    chk("tp2_hit", hp0, 8'h24);
    chk("tp2_first", fi0, 2);
    chk("tp2_count", cnt0, 3);
    idle(4);
    step(0, 1, 8'h01, 0);
    chk("tp2_hit_later", hp0, 8'h25);
    chk("tp2_first_held", fi0, 2);
    chk("tp2_count_later", cnt0, 4);

    // obj1 overlaps in each of five frames; C=2 instance hits in 1st and 4th.
    for (int f = 0; f < 5; f++) begin
      step(1, 0, 8'h00, 0);
      idle(3);
      step(0, 1, 8'h02, 0);
      chk("tp3_cool_hit", hp2[1], (f == 0 || f == 3));
      chk("tp3_nocool_hit", hp0[1], 1);
      idle(3);
    end

    // Collision on the startOfFrame cycle after a hit in the previous frame.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h10, 0);
    idle(3);
    step(1, 1, 8'h10, 0);
    chk("tp4_sof_hit", hp0, 8'h10);
    chk("tp4_prev_vec", fv0, 8'h10);
    idle(3);

    // Saturation and clear-over-increment.
    step(0, 0, 8'h00, 1);
    chk("tp5_cleared", cnt2, 0);
    for (int f = 0; f < 10; f++) begin
      step(1, 0, 8'h00, 0);
      step(0, 1, 8'(1 << (f % 8)), 0);
      idle(2);
    end
    chk("tp5_saturate", cnt2, 7);
    chk("tp5_count_wide", cnt0, 10);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h40, 1);
    chk("tp5_clr_priority0", cnt0, 0);
    chk("tp5_clr_priority2", cnt2, 0);
    idle(2);

    // Reset mid-frame with hits latched.
    step(0, 1, 8'h80, 0);
    @(negedge clk);
    pdr = 0; obj = '0; sof = 0; clr = 0;
    resetN = 1'b0;
    #1;
    modelReset();
    chk("tp6_reset_hit", hp0, 0);
    checkAll();
    @(negedge clk) resetN = 1'b1;
    step(1, 0, 8'h00, 0);
    chk("tp6_valid_after_reset", val0, 1);
    chk("tp6_vec_after_reset", fv0, 0);

    // Disabled channel 6 ignores overlap.
    en = 8'hBF;
    step(0, 1, 8'h40, 0);
    chk("tp7_disabled_hit", hp0, 0);
    chk("tp7_disabled_count", cnt0, 0);
    en = 8'hFF;
    step(0, 1, 8'h40, 0);
    en = 8'hBF;
    step(0, 0, 8'h00, 0);
    chk("tp7_drop_keeps_hit", hp0, 8'h40);
    en = 8'hFF;

    // Randomized frames.
    for (int f = 0; f < 200; f++) begin
      int len;
      len = $urandom_range(10, 40);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 9) == 0) en = 8'($urandom) | 8'($urandom);
        step((j == 0), ($urandom_range(0, 3) == 0),
             8'($urandom) & 8'($urandom) & 8'($urandom),
             ($urandom_range(0, 60) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
